// File: rtl/hsid_pkg.sv
// -----------------------------------------------------------------------------
// hsid_pkg
// Shared definitions for the hsid datapath: default element and band-count
// widths, plus the state encoding of the streaming vector adder FSM.
// -----------------------------------------------------------------------------
package hsid_pkg;

  // Default width of one datapath element.
  localparam int HSID_WORD_WIDTH      = 16;
  // Default width of band/element counts (vector lengths up to 2**8-1).
  localparam int HSID_HSP_BANDS_WIDTH = 8;

  // Operation framing for vctr_fifo_strm.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    DONE    = 2'd2
  } vctr_fifo_strm_state_t;

endpackage : hsid_pkg

// File: rtl/hsid_fifo.sv
// -----------------------------------------------------------------------------
// hsid_fifo
// Synchronous single-clock FIFO with registered read data.
//
// Ports:
//   clk      in  : clock, rising edge
//   rst_n    in  : synchronous active-low reset (empties the FIFO, clears rd_data)
//   wr_en    in  : push strobe, ignored while full
//   wr_data  in  : push data
//   rd_en    in  : pop strobe, ignored while empty
//   rd_data  out : head word, loaded on a successful pop and held otherwise
//   full     out : occupancy == 2**BUFFER_WIDTH
//   empty    out : occupancy == 0
//   count    out : current occupancy (0 .. 2**BUFFER_WIDTH)
// -----------------------------------------------------------------------------
module hsid_fifo #(
  parameter int WORD_WIDTH   = 16,
  parameter int BUFFER_WIDTH = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    wr_en,
  input  logic [WORD_WIDTH-1:0]   wr_data,
  input  logic                    rd_en,
  output logic [WORD_WIDTH-1:0]   rd_data,
  output logic                    full,
  output logic                    empty,
  output logic [BUFFER_WIDTH:0]   count
);

  localparam int DEPTH = 1 << BUFFER_WIDTH;

  logic [WORD_WIDTH-1:0]   mem [DEPTH];
  logic [BUFFER_WIDTH-1:0] wr_ptr;
  logic [BUFFER_WIDTH-1:0] rd_ptr;
  logic [BUFFER_WIDTH:0]   count_q;
  logic                    do_wr;
  logic                    do_rd;

  // Occupancy reaches DEPTH exactly when its top bit sets.
  assign full  = count_q[BUFFER_WIDTH];
  assign empty = (count_q == '0);
  assign count = count_q;

  // A push into a full FIFO and a pop from an empty one are both dropped.
  assign do_wr = wr_en && !full;
  assign do_rd = rd_en && !empty;

  // NOTE: the storage array has no reset; validity is tracked by the pointers
  // and count alone, which keeps the array a plain RAM.
  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      rd_data <= '0;
    end else begin
      if (do_wr) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_rd) begin
        rd_ptr  <= rd_ptr + 1'b1;
        rd_data <= mem[rd_ptr];
      end
      // Simultaneous push and pop leaves occupancy unchanged.
      case ({do_wr, do_rd})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule : hsid_fifo

// File: rtl/vctr_fifo_strm.sv
// -----------------------------------------------------------------------------
// vctr_fifo_strm
// Streaming element-wise vector adder. Elements of v1 and v2 are buffered in
// two input FIFOs; pairs are popped together, summed modulo 2**WORD_WIDTH and
// pushed into an output FIFO drained by the consumer. A start/done/idle/ready
// handshake frames one vector of vector_length elements per operation.
//
// Ports:
//   clk              in  : clock, rising edge
//   rst_n            in  : synchronous active-low reset
//   data_in_v1_en    in  : v1 write strobe (accepted while ready and not full)
//   data_in_v1       in  : v1 element
//   data_in_v1_full  out : v1 FIFO full
//   data_in_v2_en    in  : v2 write strobe (accepted while ready and not full)
//   data_in_v2       in  : v2 element
//   data_in_v2_full  out : v2 FIFO full
//   data_out_en      in  : output read strobe (any state)
//   data_out         out : registered read data, valid the cycle after data_out_en
//   data_out_empty   out : output FIFO empty
//   vector_length    in  : element count, sampled with start
//   start            in  : begin an operation (only honoured in IDLE)
//   done             out : all sums computed, output draining
//   idle             out : FSM in IDLE
//   ready            out : accepting input elements (COMPUTE)
// -----------------------------------------------------------------------------
module vctr_fifo_strm
  import hsid_pkg::*;
#(
  parameter int WORD_WIDTH      = HSID_WORD_WIDTH,
  parameter int HSP_BANDS_WIDTH = HSID_HSP_BANDS_WIDTH,
  parameter int BUFFER_WIDTH    = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       data_in_v1_en,
  input  logic [WORD_WIDTH-1:0]      data_in_v1,
  output logic                       data_in_v1_full,
  input  logic                       data_in_v2_en,
  input  logic [WORD_WIDTH-1:0]      data_in_v2,
  output logic                       data_in_v2_full,
  input  logic                       data_out_en,
  output logic [WORD_WIDTH-1:0]      data_out,
  output logic                       data_out_empty,
  input  logic [HSP_BANDS_WIDTH-1:0] vector_length,
  input  logic                       start,
  output logic                       done,
  output logic                       idle,
  output logic                       ready
);

  // One slot short of full: the occupancy at which an in-flight sum would
  // take the last free entry.
  localparam logic [BUFFER_WIDTH:0] OUT_LAST_SLOT = {1'b0, {BUFFER_WIDTH{1'b1}}};

  vctr_fifo_strm_state_t      state_q;
  logic [HSP_BANDS_WIDTH-1:0] len_q;
  logic [HSP_BANDS_WIDTH-1:0] issued_cnt;
  logic [HSP_BANDS_WIDTH-1:0] pushed_cnt;
  logic [HSP_BANDS_WIDTH-1:0] pushed_cnt_nxt;
  logic                       sum_valid;

  logic [WORD_WIDTH-1:0]      v1_head;
  logic [WORD_WIDTH-1:0]      v2_head;
  logic                       v1_empty;
  logic                       v2_empty;
  logic [BUFFER_WIDTH:0]      v1_count;
  logic [BUFFER_WIDTH:0]      v2_count;
  logic                       out_full;
  logic [BUFFER_WIDTH:0]      out_count;
  logic [WORD_WIDTH-1:0]      sum;

  logic                       out_room;
  logic                       pop;

  // ---------------------------------------------------------------------------
  // Status decoded straight from the state register.
  // ---------------------------------------------------------------------------
  assign idle  = (state_q == IDLE);
  assign ready = (state_q == COMPUTE);
  assign done  = (state_q == DONE);

  // ---------------------------------------------------------------------------
  // Pair issue. The input FIFOs present their popped heads one cycle after the
  // pop, so the sum for a pop at edge N is pushed at edge N+1 (sum_valid marks
  // that in-flight word). Output room counts that word as already occupying a
  // slot, so the push can never be dropped.
  // ---------------------------------------------------------------------------
  assign out_room = !out_full && !(sum_valid && (out_count == OUT_LAST_SLOT));
  assign pop      = ready && !v1_empty && !v2_empty && out_room &&
                    (issued_cnt < len_q);

  // Carry is discarded: the sum wraps modulo 2**WORD_WIDTH.
  assign sum = v1_head + v2_head;

  assign pushed_cnt_nxt = pushed_cnt + HSP_BANDS_WIDTH'(sum_valid);

  // ---------------------------------------------------------------------------
  // Control FSM and element counters.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      len_q      <= '0;
      issued_cnt <= '0;
      pushed_cnt <= '0;
      sum_valid  <= 1'b0;
    end else begin
      sum_valid <= pop;
      case (state_q)
        IDLE: begin
          if (start) begin
            len_q      <= vector_length;
            issued_cnt <= '0;
            pushed_cnt <= '0;
            state_q    <= COMPUTE;
          end
        end
        COMPUTE: begin
          if (pop) begin
            issued_cnt <= issued_cnt + 1'b1;
          end
          pushed_cnt <= pushed_cnt_nxt;
          // Leaves on the edge that pushes the last sum; a zero length
          // leaves after one cycle with nothing issued.
          if (pushed_cnt_nxt == len_q) begin
            state_q <= DONE;
          end
        end
        DONE: begin
          if (data_out_empty && !sum_valid) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // FIFOs. Input writes are gated by ready; reads of the output FIFO are
  // allowed in every state.
  // ---------------------------------------------------------------------------
  hsid_fifo #(
    .WORD_WIDTH   (WORD_WIDTH),
    .BUFFER_WIDTH (BUFFER_WIDTH)
  ) u_fifo_v1 (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (data_in_v1_en && ready),
    .wr_data (data_in_v1),
    .rd_en   (pop),
    .rd_data (v1_head),
    .full    (data_in_v1_full),
    .empty   (v1_empty),
    .count   (v1_count)
  );

  hsid_fifo #(
    .WORD_WIDTH   (WORD_WIDTH),
    .BUFFER_WIDTH (BUFFER_WIDTH)
  ) u_fifo_v2 (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (data_in_v2_en && ready),
    .wr_data (data_in_v2),
    .rd_en   (pop),
    .rd_data (v2_head),
    .full    (data_in_v2_full),
    .empty   (v2_empty),
    .count   (v2_count)
  );

  hsid_fifo #(
    .WORD_WIDTH   (WORD_WIDTH),
    .BUFFER_WIDTH (BUFFER_WIDTH)
  ) u_fifo_out (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (sum_valid),
    .wr_data (sum),
    .rd_en   (data_out_en),
    .rd_data (data_out),
    .full    (out_full),
    .empty   (data_out_empty),
    .count   (out_count)
  );

  // Input occupancies are not needed by the pairing logic; the empty flags
  // are sufficient there.
  logic unused_counts;
  assign unused_counts = ^{v1_count, v2_count};

endmodule : vctr_fifo_strm

// File: tb/tb_vctr_fifo_strm.sv
// -----------------------------------------------------------------------------
// tb_vctr_fifo_strm
// Self-checking bench for vctr_fifo_strm (WORD_WIDTH=16, HSP_BANDS_WIDTH=4,
// BUFFER_WIDTH=2). Expected sums come from a queue filled with
// (v1[i] + v2[i]) mod 65536 computed in plain integer arithmetic.
// -----------------------------------------------------------------------------
module tb_vctr_fifo_strm;

  localparam int WW = 16;
  localparam int HB = 4;
  localparam int BW = 2;

  logic          clk;
  logic          rst_n;
  logic          data_in_v1_en;
  logic [WW-1:0] data_in_v1;
  logic          data_in_v1_full;
  logic          data_in_v2_en;
  logic [WW-1:0] data_in_v2;
  logic          data_in_v2_full;
  logic          data_out_en;
  logic [WW-1:0] data_out;
  logic          data_out_empty;
  logic [HB-1:0] vector_length;
  logic          start;
  logic          done;
  logic          idle;
  logic          ready;

  vctr_fifo_strm #(
    .WORD_WIDTH      (WW),
    .HSP_BANDS_WIDTH (HB),
    .BUFFER_WIDTH    (BW)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .data_in_v1_en   (data_in_v1_en),
    .data_in_v1      (data_in_v1),
    .data_in_v1_full (data_in_v1_full),
    .data_in_v2_en   (data_in_v2_en),
    .data_in_v2      (data_in_v2),
    .data_in_v2_full (data_in_v2_full),
    .data_out_en     (data_out_en),
    .data_out        (data_out),
    .data_out_empty  (data_out_empty),
    .vector_length   (vector_length),
    .start           (start),
    .done            (done),
    .idle            (idle),
    .ready           (ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state.
  logic [WW-1:0] v1_vec [16];
  logic [WW-1:0] v2_vec [16];
  logic [WW-1:0] exp_q  [$];
  int            vec_len;
  int            i1;
  int            i2;

  // Inputs change and outputs are sampled 1 ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic build_model(input int len);
    vec_len = len;
    i1 = 0;
    i2 = 0;
    exp_q.delete();
    for (int i = 0; i < len; i++) begin
      exp_q.push_back(WW'((int'(v1_vec[i]) + int'(v2_vec[i])) % 65536));
    end
  endtask

  task automatic fill_random(input int len);
    for (int i = 0; i < len; i++) begin
      v1_vec[i] = WW'($urandom);
      v2_vec[i] = WW'($urandom);
    end
  endtask

  task automatic start_op(input int len, input string tag);
    vector_length = HB'(len);
    start = 1'b1;
    tick();
    start = 1'b0;
    n_checks++;
    if (ready !== 1'b1 || idle !== 1'b0)
      $display("FAIL %s_start: ready=%b idle=%b, want ready=1 idle=0", tag, ready, idle);
    else n_pass++;
  endtask

  // Feeds remaining inputs and drains the output until the DUT returns to
  // IDLE with every expected sum seen. v2 writes begin skew cycles after v1.
  task automatic service(input int skew, input int gap_pct, input int stall_pct,
                         input string tag);
    int  cyc;
    bit  rd_pending;
    bit  saw_done;
    bit  finished;
    logic [WW-1:0] want;
    cyc = 0;
    rd_pending = 1'b0;
    saw_done = 1'b0;
    finished = 1'b0;
    while (cyc < 400) begin
      tick();
      if (rd_pending) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL %s_extra_output: got %h, want no further output", tag, data_out);
        end else begin
          want = exp_q.pop_front();
          if (data_out !== want)
            $display("FAIL %s_sum: got %h, want %h", tag, data_out, want);
          else n_pass++;
        end
      end
      if (done === 1'b1) saw_done = 1'b1;
      if (idle === 1'b1 && exp_q.size() == 0 && i1 == vec_len && i2 == vec_len) begin
        finished = 1'b1;
        break;
      end
      if (skew > 0 && cyc < skew) begin
        n_checks++;
        if (data_out_empty !== 1'b1)
          $display("FAIL %s_no_pop_before_v2: data_out_empty=%b, want 1", tag, data_out_empty);
        else n_pass++;
      end
      data_in_v1_en = 1'b0;
      data_in_v2_en = 1'b0;
      if (i1 < vec_len && !data_in_v1_full && $urandom_range(99) >= gap_pct) begin
        data_in_v1_en = 1'b1;
        data_in_v1    = v1_vec[i1];
        i1++;
      end
      if (cyc >= skew && i2 < vec_len && !data_in_v2_full &&
          $urandom_range(99) >= gap_pct) begin
        data_in_v2_en = 1'b1;
        data_in_v2    = v2_vec[i2];
        i2++;
      end
      data_out_en = !data_out_empty && ($urandom_range(99) >= stall_pct);
      rd_pending  = data_out_en;
      cyc++;
    end
    data_in_v1_en = 1'b0;
    data_in_v2_en = 1'b0;
    data_out_en   = 1'b0;
    n_checks++;
    if (!finished)
      $display("FAIL %s_complete: %0d sums outstanding after %0d cycles, want 0", tag, exp_q.size(), cyc);
    else n_pass++;
    n_checks++;
    if (!saw_done) $display("FAIL %s_done_seen: done never 1, want 1", tag);
    else n_pass++;
  endtask

  task automatic check_reset_state(input string tag);
    n_checks++;
    if (data_out !== '0 || data_out_empty !== 1'b1)
      $display("FAIL %s_out: data_out=%h empty=%b, want 0000/1", tag, data_out, data_out_empty);
    else n_pass++;
    n_checks++;
    if (data_in_v1_full !== 1'b0 || data_in_v2_full !== 1'b0)
      $display("FAIL %s_full: v1_full=%b v2_full=%b, want 0/0", tag, data_in_v1_full, data_in_v2_full);
    else n_pass++;
    n_checks++;
    if (idle !== 1'b1 || ready !== 1'b0 || done !== 1'b0)
      $display("FAIL %s_status: idle=%b ready=%b done=%b, want 1/0/0", tag, idle, ready, done);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    check_reset_state("reset");
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic(input string tag);
    for (int i = 0; i < 8; i++) begin
      v1_vec[i] = WW'(i + 1);
      v2_vec[i] = WW'(i + 9);
    end
    build_model(8);
    n_checks++;
    if (exp_q[0] !== 16'h000A || exp_q[7] !== 16'h0018)
      $display("FAIL %s_model: first=%h last=%h, want 000a/0018", tag, exp_q[0], exp_q[7]);
    else n_pass++;
    start_op(8, tag);
    service(0, 0, 0, tag);
    n_checks++;
    if (idle !== 1'b1) $display("FAIL %s_idle: idle=%b, want 1", tag, idle);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < 8; i++) begin
      v1_vec[i] = WW'(i + 1);
      v2_vec[i] = WW'(i + 9);
    end
    build_model(8);
    start_op(8, "bp");
    // Write every cycle; once a FIFO reports full, keep strobing a junk word
    // that must be dropped.
    for (int c = 0; c < 20; c++) begin
      data_in_v1_en = 1'b0;
      data_in_v2_en = 1'b0;
      if (data_in_v1_full) begin
        data_in_v1_en = 1'b1;
        data_in_v1    = 16'hDEAD;
      end else if (i1 < 8) begin
        data_in_v1_en = 1'b1;
        data_in_v1    = v1_vec[i1];
        i1++;
      end
      if (data_in_v2_full) begin
        data_in_v2_en = 1'b1;
        data_in_v2    = 16'hBEEF;
      end else if (i2 < 8) begin
        data_in_v2_en = 1'b1;
        data_in_v2    = v2_vec[i2];
        i2++;
      end
      tick();
    end
    data_in_v1_en = 1'b0;
    data_in_v2_en = 1'b0;
    n_checks++;
    if (data_in_v1_full !== 1'b1 || data_in_v2_full !== 1'b1)
      $display("FAIL bp_inputs_full: v1_full=%b v2_full=%b, want 1/1", data_in_v1_full, data_in_v2_full);
    else n_pass++;
    n_checks++;
    if (i1 != 8 || i2 != 8)
      $display("FAIL bp_accepted: v1=%0d v2=%0d elements taken, want 8/8", i1, i2);
    else n_pass++;
    n_checks++;
    if (data_out_empty !== 1'b0 || done !== 1'b0 || ready !== 1'b1)
      $display("FAIL bp_stalled: empty=%b done=%b ready=%b, want 0/0/1", data_out_empty, done, ready);
    else n_pass++;
    service(0, 0, 0, "bp");
  endtask

  task automatic test_overflow();
    v1_vec[0] = 16'hFFFF; v2_vec[0] = 16'h0002;
    v1_vec[1] = 16'h8000; v2_vec[1] = 16'h8000;
    v1_vec[2] = 16'hFFFF; v2_vec[2] = 16'hFFFF;
    build_model(3);
    n_checks++;
    if (exp_q[0] !== 16'h0001)
      $display("FAIL ovf_model: got %h, want 0001", exp_q[0]);
    else n_pass++;
    start_op(3, "ovf");
    service(0, 0, 0, "ovf");
  endtask

  task automatic test_zero_length();
    build_model(0);
    start_op(0, "zero");
    tick();
    n_checks++;
    if (done !== 1'b1 || ready !== 1'b0 || data_out_empty !== 1'b1)
      $display("FAIL zero_done: done=%b ready=%b empty=%b, want 1/0/1", done, ready, data_out_empty);
    else n_pass++;
    tick();
    n_checks++;
    if (idle !== 1'b1 || done !== 1'b0 || data_out_empty !== 1'b1)
      $display("FAIL zero_idle: idle=%b done=%b empty=%b, want 1/0/1", idle, done, data_out_empty);
    else n_pass++;
  endtask

  task automatic test_unbalanced();
    fill_random(6);
    build_model(6);
    start_op(6, "unbal");
    service(3, 0, 0, "unbal");
  endtask

  task automatic test_midop_reset();
    for (int i = 0; i < 8; i++) begin
      v1_vec[i] = WW'(i + 1);
      v2_vec[i] = WW'(i + 9);
    end
    build_model(8);
    start_op(8, "mid");
    for (int c = 0; c < 4; c++) begin
      data_in_v1_en = 1'b1;
      data_in_v1    = v1_vec[c];
      data_in_v2_en = 1'b1;
      data_in_v2    = v2_vec[c];
      tick();
    end
    data_in_v1_en = 1'b0;
    data_in_v2_en = 1'b0;
    tick();
    tick();
    data_out_en = 1'b1;
    tick();
    data_out_en = 1'b0;
    n_checks++;
    if (data_out !== 16'h000A || ready !== 1'b1)
      $display("FAIL mid_before: data_out=%h ready=%b, want 000a/1", data_out, ready);
    else n_pass++;
    rst_n = 1'b0;
    tick();
    check_reset_state("mid_reset");
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_random();
    int len;
    for (int r = 0; r < 8; r++) begin
      len = int'($urandom_range(15, 1));
      fill_random(len);
      build_model(len);
      start_op(len, "rnd");
      service(int'($urandom_range(4)), 30, 40, "rnd");
    end
  endtask

  initial begin
    rst_n         = 1'b0;
    data_in_v1_en = 1'b0;
    data_in_v1    = '0;
    data_in_v2_en = 1'b0;
    data_in_v2    = '0;
    data_out_en   = 1'b0;
    vector_length = '0;
    start         = 1'b0;

    test_reset();
    test_basic("basic");
    test_overflow();
    test_zero_length();
    test_backpressure();
    test_unbalanced();
    test_midop_reset();
    test_basic("post_reset");
    test_random();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed so far", n_pass, n_checks);
    $fatal(1);
  end

endmodule : tb_vctr_fifo_strm
